// File: rtl/kronos_types.sv
// rtl/kronos_types.sv - shared types for the kronos memory arbiter
package kronos_types;

   // Source that owns the SRAM access launched in the previous cycle
   typedef enum logic [1:0] {
      ARB_NONE  = 2'd0,
      ARB_INSTR = 2'd1,
      ARB_DATA  = 2'd2
   } arb_src_e;

endpackage

// File: rtl/kronos_mem_arbiter.sv
// rtl/kronos_mem_arbiter.sv - fetch/load-store arbiter for one single-port SRAM
// Optional stall counters enabled by KRONOS_ARB_PERF_EN.
module kronos_mem_arbiter
   import kronos_types::*;
#(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic [31:0] instr_addr,
   input  logic        instr_req,
   output logic [31:0] instr_data,
   output logic        instr_ack,
   input  logic [31:0] data_addr,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wmask,
   output logic [31:0] data_rdata,
   output logic        data_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata
`ifdef KRONOS_ARB_PERF_EN
   ,
   output logic [31:0] arb_instr_stall_cnt,
   output logic [31:0] arb_data_stall_cnt
`endif
);

   localparam int CW = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;

   arb_src_e      inflight;
   logic [CW-1:0] burst_cnt;
   logic          guard;
   logic          gnt_data;
   logic          gnt_instr;

   assign guard = (MAX_DATA_BURST != 0) && (burst_cnt == CW'(MAX_DATA_BURST));

   // Grants are forced low while reset is sampled so nothing launches into the SRAM
   always_comb begin
      gnt_data  = rstz & data_req & (inflight != ARB_DATA) & ~guard;
      gnt_instr = rstz & instr_req & ~gnt_data;
   end

   assign mem_en    = gnt_data | gnt_instr;
   assign mem_we    = gnt_data & data_we;
   assign mem_addr  = gnt_data ? data_addr : instr_addr;
   assign mem_wdata = data_wdata;
   assign mem_wmask = data_wmask;

   assign instr_ack  = (inflight == ARB_INSTR);
   assign data_ack   = (inflight == ARB_DATA);
   assign instr_data = mem_rdata;
   assign data_rdata = mem_rdata;

   always_ff @(posedge clk) begin
      if (!rstz) begin
         inflight  <= ARB_NONE;
         burst_cnt <= '0;
      end else begin
         inflight <= gnt_data ? ARB_DATA : (gnt_instr ? ARB_INSTR : ARB_NONE);
         if (gnt_instr || !instr_req)
            burst_cnt <= '0;
         else if (gnt_data && (burst_cnt != CW'(MAX_DATA_BURST)))
            burst_cnt <= burst_cnt + 1'b1;
      end
   end

`ifdef KRONOS_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rstz) begin
         arb_instr_stall_cnt <= '0;
         arb_data_stall_cnt  <= '0;
      end else begin
         if (instr_req && !gnt_instr)
            arb_instr_stall_cnt <= arb_instr_stall_cnt + 32'd1;
         // A held request in its own ack cycle is not a stall
         if (data_req && !gnt_data && (inflight != ARB_DATA))
            arb_data_stall_cnt <= arb_data_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// tb/tb_kronos_mem_arbiter.sv - scoreboard bench for kronos_mem_arbiter
module tb_kronos_mem_arbiter;

   localparam int MAXB = 2;

   logic        clk = 1'b0;
   logic        rstz = 1'b0;
   logic [31:0] instr_addr = '0;
   logic        instr_req = 1'b0;
   logic [31:0] instr_data;
   logic        instr_ack;
   logic [31:0] data_addr = '0;
   logic        data_req = 1'b0;
   logic        data_we = 1'b0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_wmask = '0;
   logic [31:0] data_rdata;
   logic        data_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata = '0;
`ifdef KRONOS_ARB_PERF_EN
   logic [31:0] arb_instr_stall_cnt;
   logic [31:0] arb_data_stall_cnt;
`endif

   kronos_mem_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
      .clk(clk), .rstz(rstz),
      .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data), .instr_ack(instr_ack),
      .data_addr(data_addr), .data_req(data_req), .data_we(data_we), .data_wdata(data_wdata),
      .data_wmask(data_wmask), .data_rdata(data_rdata), .data_ack(data_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
`ifdef KRONOS_ARB_PERF_EN
      , .arb_instr_stall_cnt(arb_instr_stall_cnt), .arb_data_stall_cnt(arb_data_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] rd;
   } dexp_t;

   logic [31:0] sram [256];
   logic [31:0] ref_mem [256];
   logic [31:0] iq[$];
   dexp_t       dq[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;
   bit ack_seen = 0;
   int drun = 0;

   // LSU state: request held until its ack is observed
   bit          d_pending = 0;
   logic [31:0] d_addr = '0;
   bit          d_we = 0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wmask = '0;
   int          lsu_mode = 0;

   // Reference state: what was served last cycle, data run length under fetch pressure
   bit last_data = 0;
   int data_run = 0;
   int m_istall = 0;
   int m_dstall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= sram[mem_addr[9:2]];
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   // Monitor: every ack must match the oldest expectation for that port
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         chk("instr_ack", {31'b0, instr_ack}, {31'b0, iq.size() > 0});
         if (instr_ack && iq.size() > 0) chk("instr_data", instr_data, iq.pop_front());
         chk("data_ack", {31'b0, data_ack}, {31'b0, dq.size() > 0});
         if (data_ack && dq.size() > 0) begin
            dexp_t e;
            e = dq.pop_front();
            if (!e.we) chk("data_rdata", data_rdata, e.rd);
         end
         if (data_ack) begin
            ack_seen = 1;
            drun++;
            chk("data_burst_run", {31'b0, drun <= MAXB}, 32'd1);
         end else drun = 0;
      end
   end

   task automatic issue(input logic [31:0] a, input bit we, input logic [31:0] wd, input logic [3:0] wm);
      d_pending = 1; d_addr = a; d_we = we; d_wdata = wd; d_wmask = wm;
   endtask

   task automatic cycle(input bit rst, input bit ireq, input logic [31:0] iaddr);
      bit d_srv, i_srv, guard;
      @(negedge clk);
`ifdef KRONOS_ARB_PERF_EN
      chk("perf_instr", arb_instr_stall_cnt, m_istall);
      chk("perf_data", arb_data_stall_cnt, m_dstall);
`endif
      if (ack_seen) begin d_pending = 0; ack_seen = 0; end
      if (!d_pending && (lsu_mode == 2 || (lsu_mode == 1 && $urandom_range(0, 1) == 1)))
         issue(32'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      rstz = !rst; instr_req = ireq; instr_addr = iaddr;
      data_req = d_pending; data_addr = d_addr; data_we = d_we; data_wdata = d_wdata; data_wmask = d_wmask;
      #1;
      if (rst) begin
         chk("mem_en_rst", {31'b0, mem_en}, 32'd0);
         last_data = 0; data_run = 0; m_istall = 0; m_dstall = 0;
         return;
      end
      guard = (MAXB != 0) && (data_run == MAXB);
      d_srv = data_req && !last_data && !guard;
      i_srv = ireq && !d_srv;
      chk("mem_en", {31'b0, mem_en}, {31'b0, d_srv | i_srv});
      if (d_srv) begin
         dexp_t e;
         chk("mem_addr_d", mem_addr, d_addr);
         chk("mem_we_d", {31'b0, mem_we}, {31'b0, d_we});
         if (d_we) begin
            chk("mem_wdata", mem_wdata, d_wdata);
            chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, d_wmask});
         end
         e.we = d_we; e.rd = ref_mem[d_addr[9:2]];
         dq.push_back(e);
         if (d_we)
            for (int b = 0; b < 4; b++)
               if (d_wmask[b]) ref_mem[d_addr[9:2]][b*8 +: 8] = d_wdata[b*8 +: 8];
      end else if (i_srv) begin
         chk("mem_addr_i", mem_addr, iaddr);
         chk("mem_we_i", {31'b0, mem_we}, 32'd0);
         iq.push_back(ref_mem[iaddr[9:2]]);
      end
      if (ireq && !i_srv) m_istall++;
      if (data_req && !d_srv && !last_data) m_dstall++;
      if (i_srv || !ireq) data_run = 0;
      else if (d_srv) data_run++;
      last_data = d_srv;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         w = $urandom;
         sram[i] = w;
         ref_mem[i] = w;
      end
      cycle(1, 0, 0);
      mon_en = 1;
      chk("reset_instr_ack", {31'b0, instr_ack}, 32'd0);
      chk("reset_data_ack", {31'b0, data_ack}, 32'd0);
      cycle(1, 1, 32'h10);

      // Fetch only, consecutive words
      cycle(0, 1, 32'h0); cycle(0, 1, 32'h4); cycle(0, 1, 32'h8); cycle(0, 0, 0); cycle(0, 0, 0);

      // Load competing with fetch
      issue(32'h100, 0, 0, 0);
      cycle(0, 1, 32'hC); cycle(0, 1, 32'h10); cycle(0, 1, 32'h14); cycle(0, 0, 0); cycle(0, 0, 0);

      // Partial store then load back
      issue(32'h200, 1, 32'hDEADBEEF, 4'b0011);
      cycle(0, 1, 32'h18); cycle(0, 0, 0); cycle(0, 0, 0);
      issue(32'h200, 0, 0, 0);
      cycle(0, 1, 32'h200); cycle(0, 1, 32'h1C); cycle(0, 0, 0); cycle(0, 0, 0);

      // Reset in the would-be grant cycle: no ack, request served afterwards
      issue(32'h300, 0, 0, 0);
      cycle(1, 1, 32'h20);
      cycle(0, 1, 32'h24);
      chk("no_ack_after_reset", {31'b0, data_ack}, 32'd0);
      cycle(0, 1, 32'h28); cycle(0, 1, 32'h2C); cycle(0, 0, 0); cycle(0, 0, 0);

      // Continuous data pressure with fetch held high
      lsu_mode = 2;
      for (int i = 0; i < 60; i++) cycle(0, 1, 32'($urandom_range(0, 255)) << 2);

      // Random traffic with occasional resets
      lsu_mode = 1;
      for (int i = 0; i < 2000; i++)
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 32'($urandom_range(0, 255)) << 2);

      lsu_mode = 0;
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);
`ifdef KRONOS_ARB_PERF_EN
      cycle(1, 0, 0);
      cycle(0, 0, 0);
`endif
      chk("queues_drained", iq.size() + dq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
